// File: rtl/sargantana_icache_checker_pipe.sv
// Instruction-cache tag checker: one-cycle hit response, blocking miss/refill, lowest-way multihit select.
// Optional performance counters are compiled in with ICACHE_CHK_PERF_EN.
module sargantana_icache_checker_pipe #(
    parameter int N_WAY   = 4,
    parameter int TAG_W   = 20,
    parameter int LINE_W  = 128,
    parameter int FETCH_W = 32,
    localparam int WORDS  = LINE_W / FETCH_W,
    localparam int OFF_W  = (WORDS > 2) ? $clog2(WORDS) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [TAG_W-1:0]          req_tag_i,
    input  logic [OFF_W-1:0]          req_off_i,
    input  logic [N_WAY-1:0]          way_valid_i,
    input  logic [N_WAY*TAG_W-1:0]    read_tags_i,
    input  logic [N_WAY*LINE_W-1:0]   data_rd_i,
    output logic                      miss_o,
    output logic [TAG_W-1:0]          miss_tag_o,
    input  logic                      fill_valid_i,
    output logic                      fill_ready_o,
    input  logic [LINE_W-1:0]         fill_data_i,
    input  logic                      flush_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic                      rsp_hit_o,
    output logic [N_WAY-1:0]          rsp_way_o,
    output logic                      rsp_multihit_o,
    output logic [FETCH_W-1:0]        rsp_data_o,
    output logic [31:0]               hit_cnt_o,
    output logic [31:0]               miss_cnt_o,
    output logic [31:0]               multihit_cnt_o
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_FILL = 1'b1
    } state_t;

    state_t               state_r;
    logic                 rsp_valid_r;
    logic                 rsp_hit_r;
    logic [N_WAY-1:0]     rsp_way_r;
    logic                 rsp_multihit_r;
    logic [FETCH_W-1:0]   rsp_data_r;
    logic                 miss_r;
    logic [TAG_W-1:0]     miss_tag_r;
    logic [OFF_W-1:0]     miss_off_r;

    logic [N_WAY-1:0]     hit_s;
    logic [N_WAY-1:0]     sel_oh_s;
    logic                 any_hit_s;
    logic                 multihit_s;
    logic [LINE_W-1:0]    sel_line_s;
    logic [FETCH_W-1:0]   hit_word_s;
    logic [FETCH_W-1:0]   fill_word_s;
    logic                 slot_free_s;
    logic                 req_ready_s;
    logic                 fill_ready_s;
    logic                 req_fire_s;
    logic                 fill_fire_s;
    logic                 rsp_fire_s;

    function automatic logic [FETCH_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                     input logic [OFF_W-1:0]  off);
        logic [LINE_W-1:0] shifted;
        shifted = line >> (int'(off) * FETCH_W);
        return shifted[FETCH_W-1:0];
    endfunction

    // Per-way tag compare qualified by the way valid bit.
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < N_WAY; i++) begin
            hit_s[i] = way_valid_i[i] && (read_tags_i[i*TAG_W +: TAG_W] == req_tag_i);
        end
    end

    // Isolating the lowest set bit gives the priority way; anything left over is a multihit.
    assign sel_oh_s   = hit_s & (~hit_s + {{(N_WAY-1){1'b0}}, 1'b1});
    assign any_hit_s  = |hit_s;
    assign multihit_s = |(hit_s & ~sel_oh_s);

    // One-hot AND-OR mux of the selected way's line.
    always_comb begin
        sel_line_s = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (sel_oh_s[i]) begin
                sel_line_s = sel_line_s | data_rd_i[i*LINE_W +: LINE_W];
            end else begin
                sel_line_s = sel_line_s;
            end
        end
    end

    assign hit_word_s  = line_word(sel_line_s, req_off_i);
    assign fill_word_s = line_word(fill_data_i, miss_off_r);

    // Readies are gated by reset so nothing handshakes in the reset cycle.
    assign slot_free_s  = !rsp_valid_r || rsp_ready_i;
    assign req_ready_s  = !rst_i && (state_r == IDLE) && slot_free_s && !flush_i;
    assign fill_ready_s = !rst_i && (state_r == WAIT_FILL) && slot_free_s && !flush_i;
    assign req_fire_s   = req_valid_i && req_ready_s;
    assign fill_fire_s  = fill_valid_i && fill_ready_s;
    assign rsp_fire_s   = rsp_valid_r && rsp_ready_i;

    // Control FSM and the response/miss registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r        <= IDLE;
            rsp_valid_r    <= 1'b0;
            rsp_hit_r      <= 1'b0;
            rsp_way_r      <= '0;
            rsp_multihit_r <= 1'b0;
            rsp_data_r     <= '0;
            miss_r         <= 1'b0;
            miss_tag_r     <= '0;
            miss_off_r     <= '0;
        end else if (flush_i) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            miss_r      <= 1'b0;
            miss_tag_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_fire_s && any_hit_s) begin
                        rsp_valid_r    <= 1'b1;
                        rsp_hit_r      <= 1'b1;
                        rsp_way_r      <= sel_oh_s;
                        rsp_multihit_r <= multihit_s;
                        rsp_data_r     <= hit_word_s;
                    end else if (req_fire_s) begin
                        // Acceptance implies the slot was free, so any old response drains now.
                        state_r     <= WAIT_FILL;
                        rsp_valid_r <= 1'b0;
                        miss_r      <= 1'b1;
                        miss_tag_r  <= req_tag_i;
                        miss_off_r  <= req_off_i;
                    end else if (rsp_fire_s) begin
                        rsp_valid_r <= 1'b0;
                    end else begin
                        rsp_valid_r <= rsp_valid_r;
                    end
                end
                WAIT_FILL: begin
                    if (fill_fire_s) begin
                        state_r        <= IDLE;
                        rsp_valid_r    <= 1'b1;
                        rsp_hit_r      <= 1'b0;
                        rsp_way_r      <= '0;
                        rsp_multihit_r <= 1'b0;
                        rsp_data_r     <= fill_word_s;
                        miss_r         <= 1'b0;
                        miss_tag_r     <= '0;
                    end else if (rsp_fire_s) begin
                        rsp_valid_r <= 1'b0;
                    end else begin
                        rsp_valid_r <= rsp_valid_r;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                    miss_r      <= 1'b0;
                    miss_tag_r  <= '0;
                end
            endcase
        end
    end

    assign req_ready_o    = req_ready_s;
    assign fill_ready_o   = fill_ready_s;
    assign rsp_valid_o    = rsp_valid_r;
    assign rsp_hit_o      = rsp_hit_r;
    assign rsp_way_o      = rsp_way_r;
    assign rsp_multihit_o = rsp_multihit_r;
    assign rsp_data_o     = rsp_data_r;
    assign miss_o         = miss_r;
    assign miss_tag_o     = miss_tag_r;

`ifdef ICACHE_CHK_PERF_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;
    logic [31:0] multihit_cnt_r;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_r      <= 32'd0;
            miss_cnt_r     <= 32'd0;
            multihit_cnt_r <= 32'd0;
        end else if (req_fire_s && any_hit_s) begin
            hit_cnt_r      <= sat_inc(hit_cnt_r);
            multihit_cnt_r <= multihit_s ? sat_inc(multihit_cnt_r) : multihit_cnt_r;
        end else if (req_fire_s) begin
            miss_cnt_r <= sat_inc(miss_cnt_r);
        end else begin
            hit_cnt_r <= hit_cnt_r;
        end
    end

    assign hit_cnt_o      = hit_cnt_r;
    assign miss_cnt_o     = miss_cnt_r;
    assign multihit_cnt_o = multihit_cnt_r;
`else
    assign hit_cnt_o      = 32'd0;
    assign miss_cnt_o     = 32'd0;
    assign multihit_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_sargantana_icache_checker_pipe.sv
// Directed and random checks of sargantana_icache_checker_pipe against a transaction-level model.
module tb_sargantana_icache_checker_pipe;

`ifdef ICACHE_CHK_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i, req_valid_i, fill_valid_i, flush_i, rsp_ready_i;
    logic [19:0]   req_tag_i;
    logic [1:0]    req_off_i;
    logic [3:0]    way_valid_i;
    logic [19:0]   tags [4];
    logic [127:0]  lines [4];
    logic [79:0]   read_tags_i;
    logic [511:0]  data_rd_i;
    logic [127:0]  fill_data_i;
    logic          req_ready_o, miss_o, fill_ready_o, rsp_valid_o, rsp_hit_o, rsp_multihit_o;
    logic [19:0]   miss_tag_o;
    logic [3:0]    rsp_way_o;
    logic [31:0]   rsp_data_o, hit_cnt_o, miss_cnt_o, multihit_cnt_o;

    int checks = 0;
    int errors = 0;

    // Model state: pending miss, response slot, counters.
    bit            m_wait, m_rv, m_hit, m_mh;
    logic [19:0]   m_tag;
    logic [1:0]    m_off;
    logic [3:0]    m_way;
    logic [31:0]   m_data;
    logic [31:0]   m_hc, m_mc, m_ms;
    logic [31:0]   saved;

    assign read_tags_i = {tags[3], tags[2], tags[1], tags[0]};
    assign data_rd_i   = {lines[3], lines[2], lines[1], lines[0]};

    always #5 clk_i = ~clk_i;

    sargantana_icache_checker_pipe dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_tag_i(req_tag_i), .req_off_i(req_off_i),
        .way_valid_i(way_valid_i), .read_tags_i(read_tags_i), .data_rd_i(data_rd_i),
        .miss_o(miss_o), .miss_tag_o(miss_tag_o),
        .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o), .fill_data_i(fill_data_i),
        .flush_i(flush_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_hit_o(rsp_hit_o),
        .rsp_way_o(rsp_way_o), .rsp_multihit_o(rsp_multihit_o), .rsp_data_o(rsp_data_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .multihit_cnt_o(multihit_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] line, input logic [1:0] off);
        logic [127:0] t;
        t = line >> (off * 32);
        return t[31:0];
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic idle_inputs();
        rst_i = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; fill_valid_i = 1'b0;
        rsp_ready_i = 1'b1; req_tag_i = 20'd0; req_off_i = 2'd0; way_valid_i = 4'd0;
        fill_data_i = 128'd0;
    endtask

    // One clock: check readies, advance the model by the rules, check registered outputs.
    task automatic step();
        bit sf, rr, fr;
        int first, nhit;
        #3;
        sf = !m_rv || rsp_ready_i;
        rr = !rst_i && !m_wait && sf && !flush_i;
        fr = !rst_i && m_wait && sf && !flush_i;
        check("req_ready", 64'(req_ready_o), 64'(rr));
        check("fill_ready", 64'(fill_ready_o), 64'(fr));
        nhit = 0; first = -1;
        for (int i = 0; i < 4; i++) begin
            if (way_valid_i[i] && tags[i] == req_tag_i) begin
                nhit++;
                if (first < 0) first = i;
            end
        end
        if (rst_i) begin
            m_wait = 1'b0; m_rv = 1'b0; m_hit = 1'b0; m_mh = 1'b0; m_way = 4'd0; m_data = 32'd0;
            m_tag = 20'd0; m_hc = 32'd0; m_mc = 32'd0; m_ms = 32'd0;
        end else if (flush_i) begin
            m_wait = 1'b0; m_rv = 1'b0;
        end else if (req_valid_i && rr) begin
            if (nhit > 0) begin
                m_rv = 1'b1; m_hit = 1'b1; m_way = 4'd1 << first; m_mh = (nhit > 1);
                m_data = word_of(lines[first], req_off_i);
                m_hc = sat(m_hc);
                if (nhit > 1) m_mc = sat(m_mc);
            end else begin
                m_wait = 1'b1; m_tag = req_tag_i; m_off = req_off_i; m_rv = 1'b0;
                m_ms = sat(m_ms);
            end
        end else if (fill_valid_i && fr) begin
            m_rv = 1'b1; m_hit = 1'b0; m_way = 4'd0; m_mh = 1'b0;
            m_data = word_of(fill_data_i, m_off); m_wait = 1'b0;
        end else if (m_rv && rsp_ready_i) begin
            m_rv = 1'b0;
        end
        @(posedge clk_i);
        #1;
        check("rsp_valid", 64'(rsp_valid_o), 64'(m_rv));
        check("miss", 64'(miss_o), 64'(m_wait));
        check("miss_tag", 64'(miss_tag_o), m_wait ? 64'(m_tag) : 64'd0);
        if (m_rv) begin
            check("rsp_hit", 64'(rsp_hit_o), 64'(m_hit));
            check("rsp_way", 64'(rsp_way_o), 64'(m_way));
            check("rsp_multihit", 64'(rsp_multihit_o), 64'(m_mh));
            check("rsp_data", 64'(rsp_data_o), 64'(m_data));
        end
        check("hit_cnt", 64'(hit_cnt_o), PERF ? 64'(m_hc) : 64'd0);
        check("miss_cnt", 64'(miss_cnt_o), PERF ? 64'(m_ms) : 64'd0);
        check("multihit_cnt", 64'(multihit_cnt_o), PERF ? 64'(m_mc) : 64'd0);
    endtask

    initial begin
        m_wait = 1'b0; m_rv = 1'b0; m_hit = 1'b0; m_mh = 1'b0; m_tag = 20'd0; m_off = 2'd0;
        m_way = 4'd0; m_data = 32'd0; m_hc = 32'd0; m_mc = 32'd0; m_ms = 32'd0;
        for (int i = 0; i < 4; i++) begin
            tags[i]  = 20'h0;
            lines[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        idle_inputs();
        #1;

        // Reset with competing activity; readies must be low in the reset cycle.
        rst_i = 1'b1; req_valid_i = 1'b1; fill_valid_i = 1'b1; flush_i = 1'b1;
        step();
        step();
        idle_inputs();
        check("rst_hit", 64'(rsp_hit_o), 64'd0);
        check("rst_way", 64'(rsp_way_o), 64'd0);
        check("rst_mh", 64'(rsp_multihit_o), 64'd0);
        check("rst_data", 64'(rsp_data_o), 64'd0);

        // Single hit in way 2, word 3.
        tags[0] = 20'h12345; tags[2] = 20'h12345; tags[3] = 20'h00001;
        way_valid_i = 4'b1100; req_tag_i = 20'h12345; req_off_i = 2'd3; req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        check("hit_way2", 64'(rsp_way_o), 64'h4);
        check("hit_data_w3", 64'(rsp_data_o), 64'(lines[2][127:96]));
        check("hit_flag", 64'(rsp_hit_o), 64'd1);
        step();

        // Multihit on ways 1 and 3.
        tags[1] = 20'h0ABCD; tags[3] = 20'h0ABCD; tags[2] = 20'h0;
        way_valid_i = 4'b1010; req_tag_i = 20'h0ABCD; req_off_i = 2'd0; req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        check("mh_way1", 64'(rsp_way_o), 64'h2);
        check("mh_flag", 64'(rsp_multihit_o), 64'd1);
        check("mh_cnt_first", 64'(multihit_cnt_o), PERF ? 64'd1 : 64'd0);
        step();

        // Miss with offset 1, then refill.
        way_valid_i = 4'b0000; req_tag_i = 20'h55555; req_off_i = 2'd1; req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b1;
        check("miss_level", 64'(miss_o), 64'd1);
        step();
        step();
        req_valid_i = 1'b0;
        fill_valid_i = 1'b1; fill_data_i = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        step();
        fill_valid_i = 1'b0;
        check("fill_word1", 64'(rsp_data_o), 64'hBBBBBBBB);
        check("fill_hit0", 64'(rsp_hit_o), 64'd0);
        step();

        // Backpressure: response held for five cycles, then back-to-back on release.
        tags[0] = 20'h00777; way_valid_i = 4'b0001; req_tag_i = 20'h00777; req_off_i = 2'd2;
        req_valid_i = 1'b1;
        step();
        rsp_ready_i = 1'b0; fill_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("bp_data_held", 64'(rsp_data_o), 64'(lines[0][95:64]));
        fill_valid_i = 1'b0; rsp_ready_i = 1'b1;
        lines[0] = {$urandom, $urandom, $urandom, $urandom}; req_off_i = 2'd1;
        step();
        req_valid_i = 1'b0;
        check("b2b_valid", 64'(rsp_valid_o), 64'd1);
        check("b2b_data", 64'(rsp_data_o), 64'(lines[0][63:32]));
        step();

        // Flush while a fill arrives in WAIT_FILL.
        way_valid_i = 4'b0000; req_tag_i = 20'h0BEEF; req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        saved = m_ms;
        flush_i = 1'b1; fill_valid_i = 1'b1;
        step();
        flush_i = 1'b0; fill_valid_i = 1'b0;
        check("flush_no_rsp", 64'(rsp_valid_o), 64'd0);
        check("flush_miss_clr", 64'(miss_o), 64'd0);
        check("flush_miss_cnt", 64'(miss_cnt_o), PERF ? 64'(saved) : 64'd0);
        step();

`ifdef ICACHE_CHK_PERF_EN
        force dut.hit_cnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.hit_cnt_r;
        m_hc = 32'hFFFF_FFFE;
`endif
        // Three hits; the counter saturates when enabled.
        tags[1] = 20'h00321; way_valid_i = 4'b0010; req_tag_i = 20'h00321; req_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) step();
        req_valid_i = 1'b0;
        check("hit_cnt_sat", 64'(hit_cnt_o), PERF ? 64'hFFFFFFFF : 64'd0);
        step();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst_i        = ($urandom_range(0, 99) == 0);
            flush_i      = ($urandom_range(0, 24) == 0);
            req_valid_i  = ($urandom_range(0, 3) != 0);
            fill_valid_i = ($urandom_range(0, 1) == 1);
            rsp_ready_i  = ($urandom_range(0, 3) != 0);
            req_tag_i    = 20'($urandom_range(0, 3));
            req_off_i    = 2'($urandom_range(0, 3));
            way_valid_i  = 4'($urandom_range(0, 15));
            fill_data_i  = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 4; i++) begin
                tags[i]  = 20'($urandom_range(0, 3));
                lines[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_checker_pipe.md
SARGANTANA_ICACHE_CHECKER_PIPE -- requirements
Module: sargantana_icache_checker_pipe

Interface
REQ-001 SHALL take parameter N_WAY, default 4: number of ways, power of two, at least 2.
REQ-002 SHALL take parameter TAG_W, default 20: tag width.
REQ-003 SHALL take parameter LINE_W, default 128: cache line width; an integer multiple of FETCH_W.
REQ-004 SHALL take parameter FETCH_W, default 32: fetch word width; OFF_W = log2(LINE_W/FETCH_W), minimum 1.
REQ-005 SHALL have ports clk_i in 1, the single clock, and rst_i in 1, a synchronous active-high reset.
REQ-006 SHALL have req_valid_i in 1 (lookup request; array reads are valid this cycle) and req_ready_o out 1.
REQ-007 SHALL have req_tag_i in TAG_W (physical tag from the MMU) and req_off_i in OFF_W (fetch-word index within the line).
REQ-008 SHALL have way_valid_i in N_WAY, read_tags_i in N_WAY*TAG_W and data_rd_i in N_WAY*LINE_W (way i occupies slice i).
REQ-009 SHALL have miss_o out 1 (level, high while a line is awaited) and miss_tag_o out TAG_W.
REQ-010 SHALL have fill_valid_i in 1, fill_ready_o out 1 and fill_data_i in LINE_W (refill line).
REQ-011 SHALL have flush_i in 1 (kill pending work).
REQ-012 SHALL have rsp_valid_o out 1, rsp_ready_i in 1, rsp_hit_o out 1, rsp_way_o out N_WAY (one-hot), rsp_multihit_o out 1 and rsp_data_o out FETCH_W.
REQ-013 SHALL have hit_cnt_o, miss_cnt_o and multihit_cnt_o, each out 32.

Function
REQ-014 SHALL use FSM states IDLE and WAIT_FILL; slot_free = !rsp_valid_o | rsp_ready_i.
REQ-015 SHALL drive req_ready_o = (state==IDLE) & slot_free & !flush_i; a request is accepted when req_valid_i & req_ready_o.
REQ-016 SHALL compute per-way hit[i] = (read_tags_i[i]==req_tag_i) & way_valid_i[i].
REQ-017 SHALL treat multiple hits as valid: select the lowest-index hit way, drive that way alone in rsp_way_o, and set rsp_multihit_o=1.
REQ-018 SHALL, for an accepted hit at cycle N, present rsp_valid_o=1, rsp_hit_o=1 and rsp_data_o = selected line word req_off_i (bits off*FETCH_W upward) at cycle N+1, giving 1-cycle latency.
REQ-019 SHALL, for an accepted miss, produce no response, latch req_tag_i and req_off_i, and move to WAIT_FILL next cycle; miss_o=1 and miss_tag_o=latched tag throughout WAIT_FILL.
REQ-020 SHALL drive fill_ready_o = (state==WAIT_FILL) & slot_free & !flush_i.
REQ-021 SHALL, on fill handshake, load the response register with rsp_hit_o=0, rsp_way_o=0, rsp_multihit_o=0 and rsp_data_o = fill_data_i word at latched offset, then return to IDLE.
REQ-022 SHALL ignore fill_valid_i in IDLE.
REQ-023 SHALL hold all rsp_* outputs stable while rsp_valid_o & !rsp_ready_i.
REQ-024 SHALL clear rsp_valid_o when a response handshakes with no new load in the same cycle; a back-to-back load on the handshake cycle SHALL keep rsp_valid_o=1.
REQ-025 SHALL, on flush_i: clear rsp_valid_o, return to IDLE, and drop any request or fill presented in that cycle; flush SHALL win over every simultaneous event.
REQ-026 SHALL drive miss_tag_o=0 in IDLE.

Reset
REQ-027 SHALL, on rst_i: state=IDLE; rsp_valid_o, rsp_hit_o, rsp_multihit_o, rsp_way_o, rsp_data_o, miss_o and miss_tag_o = 0; counters = 0.
REQ-028 SHALL have rst_i override flush_i and all handshakes; reset asserted mid-WAIT_FILL SHALL discard the pending miss.
REQ-029 SHALL drive req_ready_o=0 and fill_ready_o=0 during the reset cycle.

Configuration
REQ-030 SHALL, with ICACHE_CHK_PERF_EN defined, count accepted hits, accepted misses and accepted multihits in 32-bit counters that saturate at 0xFFFFFFFF, are cleared only by rst_i and are unaffected by flush_i.
REQ-031 SHALL, without ICACHE_CHK_PERF_EN, keep the counter ports and tie them to 0; all other behaviour SHALL be identical.

Verification
REQ-032 SHALL cover single hit: way2 tag 0x12345 valid, req_off_i=3 -> next cycle rsp_hit_o=1, rsp_way_o=0100, rsp_data_o=line2[127:96].
REQ-033 SHALL cover multihit: ways 1 and 3 match -> rsp_way_o=0010, rsp_multihit_o=1, multihit_cnt_o=1 (macro on).
REQ-034 SHALL cover miss then fill: miss with off=1 -> miss_o=1 from next cycle, req_ready_o=0; fill 0xDDDD_CCCC_BBBB_AAAA_... -> rsp_data_o=word1, rsp_hit_o=0, then IDLE.
REQ-035 SHALL cover backpressure: rsp_ready_i=0 for 5 cycles -> outputs stable, req_ready_o=0 and fill_ready_o=0; releasing rsp_ready_i with req_valid_i=1 -> back-to-back response.
REQ-036 SHALL cover flush in WAIT_FILL with fill_valid_i the same cycle -> no response, miss_o=0 next cycle, miss_cnt_o unchanged.
REQ-037 SHALL cover counter saturation: hit_cnt_o forced to 0xFFFFFFFE, three hits -> hit_cnt_o=0xFFFFFFFF.
